pdm_mod: RTL and testbench
==========================

Name: pdm_mod

Overview:
- Second-order sigma-delta modulator. It converts a stream of 16-bit signed PCM samples into a 1-bit PDM stream.
- It is the transmit-side counterpart of the PDM decimation filter. Its BitOut/FILTER outputs drive the filter's BitIn/FILTER inputs directly, for loopback and for driving PDM DACs.
- Samples enter through a small push FIFO. Each sample is held for OSR bit periods, and FILTER marks each frame end.

Parameters:
- OSR, 512, bits per input sample (frame length); power of two, 4..1024.
- FIFO_DEPTH, 4, input sample FIFO entries; power of two, >=2.
- ACC_W, 24, signed integrator width; >=20.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- Enable  in  1  run request.
- Din  in  16  signed two's-complement PCM sample.
- PushIn  in  1  sample-write strobe; accepted only when Ready=1.
- Ready  out  1  FIFO not full (registered).
- BitOut  out  1  PDM bit, one per Clock while running.
- FILTER  out  1  one-cycle pulse on the last bit of each frame.
- Underrun  out  1  one-cycle pulse: frame ended with the FIFO empty.
- Overflow  out  1  one-cycle pulse: PushIn seen while Ready=0.
- Busy  out  1  state != IDLE.

Behaviour:
- Reset (async, Reset=1):
  - FIFO is emptied; Ready=1.
  - BitOut, FILTER, Underrun, Overflow and Busy are all 0.
  - Integrators i1 and i2 are 0; cur_sample=0; bit_cnt=0; state=IDLE.
  - Reset mid-frame aborts immediately. No FILTER is issued for the partial frame.
- FIFO:
  - Write on PushIn&Ready. Pop is internal.
  - A push and pop in the same cycle is legal; the count is unchanged.
  - Ready is derived from the registered count. A pop does not re-enable Ready until the next cycle.
  - PushIn while Ready=0 drops the sample and pulses Overflow on the next cycle.
- States IDLE, RUN, DRAIN:
  - IDLE: BitOut=0 and the integrators are held at 0. If Enable=1 and the FIFO is non-empty: pop into cur_sample, bit_cnt=0, go to RUN.
  - RUN: one modulator step per cycle and bit_cnt++. At bit_cnt==OSR-1:
    - FILTER=1 that cycle and bit_cnt wraps to 0.
    - If the FIFO is non-empty, pop a new cur_sample, which is used from the next bit.
    - Otherwise hold cur_sample and pulse Underrun.
    - If Enable=0 at any point in the frame, go to DRAIN.
  - DRAIN: continue stepping until bit_cnt==OSR-1. Issue FILTER, then go to IDLE with no pop. Integrators are cleared on entry to IDLE.
  - Re-asserting Enable during DRAIN does not cancel it.
- Latency: a sample accepted on edge N while IDLE with Enable=1 is popped on edge N+1. Its first BitOut is registered on edge N+2.
- Modulator step (all signed ACC_W arithmetic):
  - x = sign-extended cur_sample.
  - fb = BitOut ? +32767 : -32768.
  - i1' = sat(i1 + x - fb).
  - i2' = sat(i2 + i1' - fb).
  - BitOut' = (i2' >= 0).
  - sat clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; the integrators never wrap.
- Density: the expected ones count per frame is about OSR*(x+32768)/65535.
- FILTER, Underrun and Overflow are registered single-cycle pulses. FILTER is coincident with the frame's last BitOut.

Optional Feature:
- Macro: PDM_MOD_DITHER_EN.
- When defined:
  - A 16-bit Galois LFSR (polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances every modulator step.
  - Its low 4 bits, sign-extended, are added to i2' before the sign decision only. The stored i2 is not dithered.
  - This breaks idle tones.
- When undefined: there is no LFSR, and the decision is exactly i2' >= 0.
- Tests below use the undefined build unless stated; with dither, density tolerances widen to ±4.

Test Plan:
- Reset then idle 100 cycles with Enable=1 and no pushes -> BitOut=0, FILTER=0, Busy=0, Ready=1 throughout.
- Push Din=0 repeatedly, keeping the FIFO fed, OSR=512 -> FILTER every 512 cycles; ones per frame 256±2 from the 3rd frame on; Underrun never pulses.
- Push Din=16384, then Din=-16384, then Din=-32768 (one frame each) -> ones per frame 384±3, then 128±3, then <=3. Integrators stay within saturation bounds (checked by assertion).
- Push a single sample then stop -> one Underrun pulse per frame end from the first frame end on; cur_sample is held, so the density is unchanged.
- With Enable=0, push 5 samples on consecutive cycles -> Ready falls after the 4th; Overflow pulses once; FIFO count=4; Busy stays 0.
- Running, drop Enable at bit 100 of a frame -> stepping continues to bit 511 with FILTER at bit 511, then IDLE with BitOut=0. A separate run asserts Reset at bit 200 -> all outputs go to 0 immediately with no FILTER.

Source files
------------

// File: rtl/pdm_mod.sv
// Second-order sigma-delta PCM-to-PDM modulator with push FIFO and frame strobe.
// Optional LFSR dither on the bit decision: define PDM_MOD_DITHER_EN.
module pdm_mod #(
  parameter int OSR        = 512,
  parameter int FIFO_DEPTH = 4,
  parameter int ACC_W      = 24
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Enable,
  input  logic signed [15:0] Din,
  input  logic               PushIn,
  output logic               Ready,
  output logic               BitOut,
  output logic               FILTER,
  output logic               Underrun,
  output logic               Overflow,
  output logic               Busy
);
  localparam int CW = $clog2(OSR);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = ACC_W + 2;
  localparam logic signed [EW-1:0] MAX_E = EW'({1'b0, {(ACC_W-1){1'b1}}});
  localparam logic signed [EW-1:0] MIN_E = ~MAX_E;
  localparam logic signed [EW-1:0] FB_P  = EW'(32767);
  localparam logic signed [EW-1:0] FB_N  = -EW'(32768);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;

  logic signed [15:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             count;
  logic signed [15:0]      cur_sample;
  logic [CW-1:0]           bit_cnt;
  logic signed [ACC_W-1:0] i1, i2, i1_n, i2_n;
  logic signed [EW-1:0]    x_e, fb_e, s1, s2;
  logic                    push, pop, step, last, to_idle, undr, bit_n;

  assign Ready = (count != (AW+1)'(FIFO_DEPTH));
  assign push  = PushIn & Ready;
  assign Busy  = (state != IDLE);
  assign last  = (bit_cnt == CW'(OSR-1));

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    step     = 1'b0;
    to_idle  = 1'b0;
    undr     = 1'b0;
    case (state)
      IDLE: if (Enable && count != '0) begin
        pop      = 1'b1;
        state_nx = RUN;
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          if (Enable) begin
            pop  = (count != '0);
            undr = (count == '0);
          end else begin
            state_nx = IDLE;
            to_idle  = 1'b1;
          end
        end else if (!Enable) state_nx = DRAIN;
      end
      DRAIN: begin
        step = 1'b1;
        if (last) begin
          state_nx = IDLE;
          to_idle  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  function automatic logic signed [ACC_W-1:0] sat(input logic signed [EW-1:0] v);
    if (v > MAX_E)      return MAX_E[ACC_W-1:0];
    else if (v < MIN_E) return MIN_E[ACC_W-1:0];
    else                return v[ACC_W-1:0];
  endfunction

  // Extra headroom bits so the sums cannot wrap before saturation
  always_comb begin
    x_e  = {{(EW-16){cur_sample[15]}}, cur_sample};
    fb_e = BitOut ? FB_P : FB_N;
    s1   = {{2{i1[ACC_W-1]}}, i1} + x_e - fb_e;
    i1_n = sat(s1);
    s2   = {{2{i2[ACC_W-1]}}, i2} + {{2{i1_n[ACC_W-1]}}, i1_n} - fb_e;
    i2_n = sat(s2);
  end

`ifdef PDM_MOD_DITHER_EN
  logic [15:0]      lfsr;
  logic [ACC_W:0]   dsum;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset)     lfsr <= 16'hACE1;
    else if (step) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  // Dither only perturbs the decision; the stored i2 stays clean
  assign dsum  = {i2_n[ACC_W-1], i2_n} + {{(ACC_W-3){lfsr[3]}}, lfsr[3:0]};
  assign bit_n = ~dsum[ACC_W];
`else
  assign bit_n = ~i2_n[ACC_W-1];
`endif

  always_ff @(posedge Clock)
    if (push) fifo_mem[wr_ptr] <= Din;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      cur_sample <= '0;
      bit_cnt    <= '0;
      i1         <= '0;
      i2         <= '0;
      BitOut     <= 1'b0;
      FILTER     <= 1'b0;
      Underrun   <= 1'b0;
      Overflow   <= 1'b0;
    end else begin
      state    <= state_nx;
      FILTER   <= step & last;
      Underrun <= undr;
      Overflow <= PushIn & ~Ready;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        cur_sample <= fifo_mem[rd_ptr];
      end
      count   <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      bit_cnt <= step ? bit_cnt + 1'b1 : '0;
      if (step && !to_idle) begin
        i1     <= i1_n;
        i2     <= i2_n;
        BitOut <= bit_n;
      end else begin
        // Last bit still goes out with FILTER; integrators restart from zero
        i1     <= '0;
        i2     <= '0;
        BitOut <= step ? bit_n : 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pdm_mod.sv
// Randomized bench for pdm_mod: per-frame bitstreams compared against an arithmetic model.
module tb_pdm_mod;
  localparam int OSR = 512;
  localparam longint AMAX = (64'sd1 <<< 23) - 1;
  localparam longint AMIN = -(64'sd1 <<< 23);

  logic Clock = 1'b0, Reset = 1'b1, Enable = 1'b0, PushIn = 1'b0;
  logic signed [15:0] Din = '0;
  logic Ready, BitOut, FILTER, Underrun, Overflow, Busy;

  pdm_mod #(.OSR(OSR), .FIFO_DEPTH(4), .ACC_W(24)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Din(Din), .PushIn(PushIn),
    .Ready(Ready), .BitOut(BitOut), .FILTER(FILTER), .Underrun(Underrun),
    .Overflow(Overflow), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  int errs = 0, checks = 0;
  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic signed [15:0] s [9];
  int     ones_q [$];
  int     filt_cnt = 0, und_cnt = 0, ovf_cnt = 0, nb = 0, ones = 0, fidx = 0;
  bit     frame_bits [1024];
  bit     busy_d = 1'b0;
  longint mi1 = 0, mi2 = 0;
  bit     mb = 1'b0;

  function automatic longint clamp(input longint v);
    return (v > AMAX) ? AMAX : (v < AMIN) ? AMIN : v;
  endfunction

  // Reference modulator: one step of the sigma-delta equations on integers
  function automatic bit mstep(input longint x);
    longint fb;
    fb  = mb ? 32767 : -32768;
    mi1 = clamp(mi1 + x - fb);
    mi2 = clamp(mi2 + mi1 - fb);
    mb  = (mi2 >= 0);
    return mb;
  endfunction

  always @(negedge Clock) begin
    if (Reset) begin
      nb = 0; ones = 0; mi1 = 0; mi2 = 0; mb = 1'b0; busy_d = 1'b0;
    end else begin
      if (busy_d && nb < 1024) begin
        frame_bits[nb] = BitOut;
        nb++;
        ones += int'(BitOut);
      end
      if (Underrun) und_cnt++;
      if (Overflow) ovf_cnt++;
      if (FILTER) begin
        int mism;
        longint x;
        mism = 0;
        x = longint'(s[(fidx > 8) ? 8 : fidx]);
        chk("frame_len", nb, OSR);
        for (int k = 0; k < nb; k++)
          if (mstep(x) != frame_bits[k]) mism++;
        chk("frame_bits", mism, 0);
        ones_q.push_back(ones);
        fidx++; filt_cnt++; nb = 0; ones = 0;
        if (!Busy) begin mi1 = 0; mi2 = 0; mb = 1'b0; end
      end
      busy_d = Busy;
    end
  end

  function automatic longint absd(input longint a, input longint b);
    return (a > b) ? a - b : b - a;
  endfunction

  initial begin
    int bad, idx, cyc, und8, f0;
    bit got8;
    s[0] = 0; s[1] = 0; s[2] = 0; s[3] = 16384; s[4] = -16384; s[5] = -32768;
    for (int i = 6; i < 9; i++) s[i] = 16'($urandom);

    // reset state
    #1;
    chk("rst_bitout", BitOut, 0);   chk("rst_filter", FILTER, 0);
    chk("rst_underrun", Underrun, 0); chk("rst_overflow", Overflow, 0);
    chk("rst_busy", Busy, 0);       chk("rst_ready", Ready, 1);

    // idle with Enable and an empty FIFO stays quiet
    @(negedge Clock); Reset = 1'b0; Enable = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge Clock);
      if (BitOut || FILTER || Busy || !Ready) bad++;
    end
    chk("idle_quiet", bad, 0);

    // fill FIFO while disabled; fifth push must be dropped
    Enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      if (i == 4) chk("ready_full", Ready, 0);
      PushIn = 1'b1;
      Din = (i < 4) ? s[i] : 16'sd12345;
    end
    @(negedge Clock); PushIn = 1'b0;
    @(negedge Clock);
    chk("ovf_pulses", ovf_cnt, 1);
    chk("fifo_count", dut.count, 4);
    chk("busy_disabled", Busy, 0);

    // run, keeping the FIFO fed until the sample list runs out
    Enable = 1'b1; idx = 4; cyc = 0; got8 = 1'b0; und8 = -1;
    while (filt_cnt < 11 && cyc < 8000) begin
      @(negedge Clock); cyc++;
      if (filt_cnt == 8 && !got8) begin und8 = und_cnt; got8 = 1'b1; end
      if (Ready && idx < 9) begin PushIn = 1'b1; Din = s[idx]; idx++; end
      else PushIn = 1'b0;
    end
    PushIn = 1'b0;
    chk("reach_11_frames", filt_cnt, 11);
    chk("no_underrun_fed", und8, 0);

    // drop Enable mid-frame; frame must drain to its end
    repeat (100) @(negedge Clock);
    Enable = 1'b0;
    cyc = 0;
    while (Busy && cyc < 1000) begin @(negedge Clock); cyc++; end
    chk("drained", Busy, 0);
    @(negedge Clock);
    chk("drain_filter_cnt", filt_cnt, 12);
    chk("underrun_cnt", und_cnt, 3);
    chk("idle_bitout", BitOut, 0);
    chk("idle_ready", Ready, 1);

    if (ones_q.size() >= 12) begin
      chk("dens_zero", absd(ones_q[2], 256) <= 2, 1);
      chk("dens_pos_half", absd(ones_q[3], 384) <= 3, 1);
      chk("dens_neg_half", absd(ones_q[4], 128) <= 3, 1);
      chk("dens_neg_full", ones_q[5] <= 3, 1);
      chk("dens_held_a", absd(ones_q[9], ones_q[8]) <= 2, 1);
      chk("dens_held_b", absd(ones_q[10], ones_q[8]) <= 2, 1);
    end else chk("frames_recorded", ones_q.size(), 12);

    // latency, then reset in the middle of a frame
    Enable = 1'b1;
    @(negedge Clock); PushIn = 1'b1; Din = 16'sd8000;
    @(negedge Clock); PushIn = 1'b0;
    chk("lat_busy_n", Busy, 0);
    @(negedge Clock);
    chk("lat_busy_n1", Busy, 1);
    cyc = 0;
    while (nb < 200 && cyc < 1000) begin @(negedge Clock); cyc++; end
    chk("reach_bit200", nb >= 200, 1);
    f0 = filt_cnt;
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_bitout", BitOut, 0); chk("mid_rst_filter", FILTER, 0);
    chk("mid_rst_busy", Busy, 0);     chk("mid_rst_ready", Ready, 1);
    repeat (3) @(negedge Clock);
    Enable = 1'b0; Reset = 1'b0;
    repeat (3) @(negedge Clock);
    chk("no_partial_filter", filt_cnt, f0);
    chk("post_rst_count", dut.count, 0);
    chk("post_rst_busy", Busy, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
